// File: rtl/apb_bridge_arbiter_if.sv
// Bus bundle for apb_bridge_arbiter: two req/ack requester ports and the AHB-Lite
// master port towards the AHB-to-APB bridge.
interface apb_bridge_arbiter_if;
    logic        r0_req;
    logic [31:0] r0_addr;
    logic        r0_write;
    logic [31:0] r0_wdata;
    logic        r0_ack;
    logic [31:0] r0_rdata;
    logic        r0_err;

    logic        r1_req;
    logic [31:0] r1_addr;
    logic        r1_write;
    logic [31:0] r1_wdata;
    logic        r1_ack;
    logic [31:0] r1_rdata;
    logic        r1_err;

    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic [1:0]  HRESP;

    // Arbiter view: serves the requesters and masters the bridge.
    modport master (
        input  r0_req, r0_addr, r0_write, r0_wdata,
        output r0_ack, r0_rdata, r0_err,
        input  r1_req, r1_addr, r1_write, r1_wdata,
        output r1_ack, r1_rdata, r1_err,
        output HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    // Environment view: requesters plus the bridge.
    modport slave (
        output r0_req, r0_addr, r0_write, r0_wdata,
        input  r0_ack, r0_rdata, r0_err,
        output r1_req, r1_addr, r1_write, r1_wdata,
        input  r1_ack, r1_rdata, r1_err,
        input  HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/apb_bridge_arbiter.sv
// Round-robin arbiter sharing the bridge's AHB-Lite slave port between two
// single-word requesters, with a data-phase watchdog that aborts hung transfers.
module apb_bridge_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic                 HCLK,
    input  logic                 HRESETN,
    apb_bridge_arbiter_if.master bus
);

    localparam int unsigned WD_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic        WD_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_RESP  = 3'd3,
        ST_FLUSH = 3'd4
    } state_t;

    state_t            state_r;
    logic              last_grant_r;
    logic              owner_r;
    logic              abort_r;
    logic [WD_W-1:0]   wd_cnt_r;
    logic              hsel_r;
    logic [31:0]       haddr_r;
    logic [1:0]        htrans_r;
    logic              hwrite_r;
    logic [31:0]       hwdata_r;
    logic              ack0_r;
    logic              ack1_r;
    logic [31:0]       rdata0_r;
    logic [31:0]       rdata1_r;
    logic              err0_r;
    logic              err1_r;

    logic              grant_valid_s;
    logic              grant_sel_s;
    logic [31:0]       sel_addr_s;
    logic              sel_write_s;
    logic [31:0]       sel_wdata_s;
    logic [31:0]       cpl_rdata_s;
    logic              cpl_err_s;
    logic              wd_expired_s;
    logic              hresp_unused_s;

    assign wd_expired_s   = WD_EN && (wd_cnt_r == WD_LAST);
    assign hresp_unused_s = bus.HRESP[1];

    // Round-robin pick: on a tie the requester that did not win last time goes next.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_sel_s   = last_grant_r;
        if (bus.r0_req && bus.r1_req) begin
            grant_valid_s = 1'b1;
            grant_sel_s   = ~last_grant_r;
        end else if (bus.r0_req) begin
            grant_valid_s = 1'b1;
            grant_sel_s   = 1'b0;
        end else if (bus.r1_req) begin
            grant_valid_s = 1'b1;
            grant_sel_s   = 1'b1;
        end else begin
            grant_valid_s = 1'b0;
            grant_sel_s   = last_grant_r;
        end
    end

    // Command fields of the requester being granted.
    always_comb begin
        sel_addr_s  = bus.r0_addr;
        sel_write_s = bus.r0_write;
        sel_wdata_s = bus.r0_wdata;
        if (grant_sel_s) begin
            sel_addr_s  = bus.r1_addr;
            sel_write_s = bus.r1_write;
            sel_wdata_s = bus.r1_wdata;
        end else begin
            sel_addr_s  = bus.r0_addr;
            sel_write_s = bus.r0_write;
            sel_wdata_s = bus.r0_wdata;
        end
    end

    // Response to hand back: bridge data when it completes, otherwise the abort pattern.
    always_comb begin
        cpl_rdata_s = ERR_RDATA;
        cpl_err_s   = 1'b1;
        if (bus.HREADYOUT) begin
            cpl_rdata_s = hwrite_r ? 32'h0000_0000 : bus.HRDATA;
            cpl_err_s   = bus.HRESP[0];
        end else begin
            cpl_rdata_s = ERR_RDATA;
            cpl_err_s   = 1'b1;
        end
    end

    // Transfer sequencer with all bus and requester outputs registered.
    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state_r      <= ST_IDLE;
            last_grant_r <= 1'b1;
            owner_r      <= 1'b0;
            abort_r      <= 1'b0;
            wd_cnt_r     <= '0;
            hsel_r       <= 1'b0;
            haddr_r      <= 32'h0000_0000;
            htrans_r     <= 2'b00;
            hwrite_r     <= 1'b0;
            hwdata_r     <= 32'h0000_0000;
            ack0_r       <= 1'b0;
            ack1_r       <= 1'b0;
            rdata0_r     <= 32'h0000_0000;
            rdata1_r     <= 32'h0000_0000;
            err0_r       <= 1'b0;
            err1_r       <= 1'b0;
        end else begin
            ack0_r <= 1'b0;
            ack1_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (grant_valid_s) begin
                        owner_r      <= grant_sel_s;
                        last_grant_r <= grant_sel_s;
                        haddr_r      <= sel_addr_s;
                        hwrite_r     <= sel_write_s;
                        hwdata_r     <= sel_wdata_s;
                        hsel_r       <= 1'b1;
                        htrans_r     <= 2'b10;
                        state_r      <= ST_ADDR;
                    end else begin
                        state_r      <= ST_IDLE;
                    end
                end
                ST_ADDR: begin
                    if (bus.HREADYOUT) begin
                        hsel_r   <= 1'b0;
                        htrans_r <= 2'b00;
                        wd_cnt_r <= '0;
                        state_r  <= ST_DATA;
                    end else begin
                        state_r  <= ST_ADDR;
                    end
                end
                ST_DATA: begin
                    // A completing bridge wins over a watchdog expiring on the same cycle.
                    if (bus.HREADYOUT || wd_expired_s) begin
                        if (owner_r) begin
                            ack1_r   <= 1'b1;
                            rdata1_r <= cpl_rdata_s;
                            err1_r   <= cpl_err_s;
                        end else begin
                            ack0_r   <= 1'b1;
                            rdata0_r <= cpl_rdata_s;
                            err0_r   <= cpl_err_s;
                        end
                        abort_r  <= ~bus.HREADYOUT;
                        wd_cnt_r <= '0;
                        state_r  <= ST_RESP;
                    end else begin
                        wd_cnt_r <= wd_cnt_r + WD_W'(1);
                        state_r  <= ST_DATA;
                    end
                end
                ST_RESP: begin
                    state_r <= abort_r ? ST_FLUSH : ST_IDLE;
                end
                ST_FLUSH: begin
                    if (bus.HREADYOUT) begin
                        abort_r <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_FLUSH;
                    end
                end
                default: begin
                    hsel_r   <= 1'b0;
                    htrans_r <= 2'b00;
                    abort_r  <= 1'b0;
                    wd_cnt_r <= '0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.HSEL     = hsel_r;
    assign bus.HADDR    = haddr_r;
    assign bus.HTRANS   = htrans_r;
    assign bus.HWRITE   = hwrite_r;
    assign bus.HWDATA   = hwdata_r;
    assign bus.HREADY   = bus.HREADYOUT;
    assign bus.r0_ack   = ack0_r;
    assign bus.r0_rdata = rdata0_r;
    assign bus.r0_err   = err0_r;
    assign bus.r1_ack   = ack1_r;
    assign bus.r1_rdata = rdata1_r;
    assign bus.r1_err   = err1_r;

endmodule

// File: tb/tb_apb_bridge_arbiter.sv
// Random two-requester traffic against a bridge model with wait states, errors and
// hangs, checked cycle by cycle against a transfer-timeline reference model.
`timescale 1ns/1ps
module tb_apb_bridge_arbiter;
    localparam int          TO       = 8;
    localparam logic [31:0] ERRD     = 32'hDEAD_BEEF;
    localparam int          N_CYCLES = 4000;

    typedef enum {M_FREE, M_ADDR, M_DATA, M_RESP, M_FLUSH} mphase_t;

    logic HCLK = 1'b0;
    logic HRESETN = 1'b0;
    apb_bridge_arbiter_if bus();

    apb_bridge_arbiter #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(ERRD)) dut (
        .HCLK    (HCLK),
        .HRESETN (HRESETN),
        .bus     (bus)
    );

    always #5 HCLK = ~HCLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    // requester side
    logic        pend    [2];
    logic [31:0] c_addr  [2];
    logic        c_write [2];
    logic [31:0] c_wdata [2];

    // reference model of the shared bus timeline
    mphase_t     m_phase;
    int          m_owner;
    int          m_last;
    int          m_dcnt;
    logic        m_abort;
    logic [31:0] m_addr, m_wdata, m_exp_rdata;
    logic        m_write, m_exp_err;
    logic [31:0] m_rdata [2];

    // bridge model
    logic        br_active, br_err;
    int          br_left;

    logic        rdy_v;
    logic [1:0]  hresp_v;
    logic [31:0] hrdata_v;
    int          win;
    logic        reset_done = 1'b0;

    task automatic new_cmd(input int n);
        pend[n]    = 1'b1;
        c_addr[n]  = $urandom;
        c_write[n] = 1'($urandom_range(0, 1));
        c_wdata[n] = $urandom;
    endtask

    task automatic apply_reqs();
        bus.r0_req = pend[0]; bus.r0_addr = c_addr[0]; bus.r0_write = c_write[0]; bus.r0_wdata = c_wdata[0];
        bus.r1_req = pend[1]; bus.r1_addr = c_addr[1]; bus.r1_write = c_write[1]; bus.r1_wdata = c_wdata[1];
    endtask

    task automatic reset_env();
        for (int n = 0; n < 2; n++) begin
            pend[n] = 1'b0; c_addr[n] = 32'h0; c_write[n] = 1'b0; c_wdata[n] = 32'h0;
            m_rdata[n] = 32'h0;
        end
        apply_reqs();
        m_phase = M_FREE; m_owner = 0; m_last = 1; m_dcnt = 0; m_abort = 1'b0;
        br_active = 1'b0; br_err = 1'b0; br_left = 0;
        bus.HREADYOUT = 1'b1; bus.HRESP = 2'b00; bus.HRDATA = 32'h0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_hsel"},   bus.HSEL,     32'd0);
        check_eq({pfx, "_htrans"}, bus.HTRANS,   32'd0);
        check_eq({pfx, "_ack0"},   bus.r0_ack,   32'd0);
        check_eq({pfx, "_ack1"},   bus.r1_ack,   32'd0);
        check_eq({pfx, "_rdata0"}, bus.r0_rdata, 32'd0);
        check_eq({pfx, "_rdata1"}, bus.r1_rdata, 32'd0);
        check_eq({pfx, "_err0"},   bus.r0_err,   32'd0);
        check_eq({pfx, "_err1"},   bus.r1_err,   32'd0);
    endtask

    initial begin
        reset_env();
        HRESETN = 1'b0;
        repeat (3) @(negedge HCLK);
        check_reset_outputs("rst");
        check_eq("rst_haddr",  bus.HADDR,  32'd0);
        check_eq("rst_hwrite", bus.HWRITE, 32'd0);
        check_eq("rst_hwdata", bus.HWDATA, 32'd0);
        HRESETN = 1'b1;

        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            @(negedge HCLK);

            // asynchronous reset in the middle of a data phase
            if (!reset_done && cyc > N_CYCLES / 2 && m_phase == M_DATA) begin
                #2;
                HRESETN = 1'b0;
                #1;
                check_reset_outputs("midrst");
                reset_env();
                reset_done = 1'b1;
                @(negedge HCLK);
                HRESETN = 1'b1;
                continue;
            end

            // outputs expected in this cycle
            if (m_phase == M_RESP) m_rdata[m_owner] = m_exp_rdata;
            check_eq("hsel",   bus.HSEL,   (m_phase == M_ADDR) ? 32'd1 : 32'd0);
            check_eq("htrans", bus.HTRANS, (m_phase == M_ADDR) ? 32'd2 : 32'd0);
            check_eq("hready", bus.HREADY, bus.HREADYOUT);
            if (m_phase == M_ADDR) begin
                check_eq("haddr",  bus.HADDR,  m_addr);
                check_eq("hwrite", bus.HWRITE, m_write);
            end
            if (m_phase == M_DATA) check_eq("hwdata", bus.HWDATA, m_wdata);
            check_eq("ack0", bus.r0_ack, (m_phase == M_RESP && m_owner == 0) ? 32'd1 : 32'd0);
            check_eq("ack1", bus.r1_ack, (m_phase == M_RESP && m_owner == 1) ? 32'd1 : 32'd0);
            if (m_phase == M_RESP)
                check_eq("err", (m_owner == 0) ? bus.r0_err : bus.r1_err, m_exp_err);
            check_eq("rdata0", bus.r0_rdata, m_rdata[0]);
            check_eq("rdata1", bus.r1_rdata, m_rdata[1]);

            // requesters: retire on ack, then often raise a fresh command at once
            if (m_phase == M_RESP) pend[m_owner] = 1'b0;
            for (int n = 0; n < 2; n++)
                if (!pend[n] && $urandom_range(0, 3) != 0) new_cmd(n);
            apply_reqs();

            // bridge
            hrdata_v = $urandom;
            if (br_active) begin
                if (br_left > 0) begin
                    rdy_v   = 1'b0;
                    hresp_v = {1'($urandom_range(0, 1)), br_err && (br_left == 1)};
                    br_left--;
                end else begin
                    rdy_v     = 1'b1;
                    hresp_v   = {1'($urandom_range(0, 1)), br_err};
                    br_active = 1'b0;
                end
            end else begin
                rdy_v   = (bus.HSEL && bus.HTRANS == 2'b10) ? ($urandom_range(0, 3) != 0) : 1'b1;
                hresp_v = {1'($urandom_range(0, 1)), 1'b0};
                if (bus.HSEL && bus.HTRANS == 2'b10 && rdy_v) begin
                    int r;
                    r = $urandom_range(0, 15);
                    br_active = 1'b1;
                    br_err    = 1'b0;
                    if (r < 8)       br_left = r % 4;
                    else if (r < 11) br_left = (r == 8) ? TO - 1 : TO;
                    else if (r < 13) br_left = $urandom_range(TO + 1, 20);
                    else begin
                        br_left = $urandom_range(1, 3);
                        br_err  = 1'b1;
                    end
                end
            end
            bus.HREADYOUT = rdy_v;
            bus.HRESP     = hresp_v;
            bus.HRDATA    = hrdata_v;

            // advance the reference timeline by one cycle
            case (m_phase)
                M_FREE: begin
                    if (pend[0] || pend[1]) begin
                        win = (pend[0] && pend[1]) ? 1 - m_last : (pend[1] ? 1 : 0);
                        m_last  = win;
                        m_owner = win;
                        m_addr  = c_addr[win];
                        m_write = c_write[win];
                        m_wdata = c_wdata[win];
                        m_phase = M_ADDR;
                    end
                end
                M_ADDR: if (rdy_v) begin m_phase = M_DATA; m_dcnt = 0; end
                M_DATA: begin
                    m_dcnt++;
                    if (rdy_v) begin
                        m_exp_rdata = m_write ? 32'h0 : hrdata_v;
                        m_exp_err   = hresp_v[0];
                        m_abort     = 1'b0;
                        m_phase     = M_RESP;
                    end else if (m_dcnt == TO) begin
                        m_exp_rdata = ERRD;
                        m_exp_err   = 1'b1;
                        m_abort     = 1'b1;
                        m_phase     = M_RESP;
                    end
                end
                M_RESP:  m_phase = m_abort ? M_FLUSH : M_FREE;
                M_FLUSH: if (rdy_v) m_phase = M_FREE;
                default: m_phase = M_FREE;
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
